// File: rtl/el2_ifu_ic_refill_if.sv
// rtl/el2_ifu_ic_refill_if.sv - Miss request, bus beat, array write and status bundle for the I-cache refill sequencer
//
// Groups every non-clock/reset signal of el2_ifu_ic_refill.
//   master : requester side (drives miss/flush/ecc/bus beats, observes array write port and status)
//   slave  : refill sequencer side
// Signals:
//   io_miss_req/io_miss_addr/io_miss_way   refill request, halfword address, one-hot victim way
//   io_flush                               abort the current refill
//   io_dec_tlu_core_ecc_disable            force check bits to zero
//   io_bus_valid/io_bus_data/io_bus_err    64-bit beat stream, io_bus_ready back-pressure
//   io_ic_wr_en/io_ic_rw_addr/io_ic_wr_data_0/1   data array write port
//   io_busy/io_done/io_err                 status
interface el2_ifu_ic_refill_if;
    logic        io_miss_req;
    logic [30:0] io_miss_addr;
    logic [1:0]  io_miss_way;
    logic        io_flush;
    logic        io_dec_tlu_core_ecc_disable;
    logic        io_bus_valid;
    logic [63:0] io_bus_data;
    logic        io_bus_err;
    logic        io_bus_ready;
    logic [1:0]  io_ic_wr_en;
    logic [30:0] io_ic_rw_addr;
    logic [70:0] io_ic_wr_data_0;
    logic [70:0] io_ic_wr_data_1;
    logic        io_busy;
    logic        io_done;
    logic        io_err;

    modport master (
        output io_miss_req, io_miss_addr, io_miss_way, io_flush, io_dec_tlu_core_ecc_disable,
        output io_bus_valid, io_bus_data, io_bus_err,
        input  io_bus_ready, io_ic_wr_en, io_ic_rw_addr, io_ic_wr_data_0, io_ic_wr_data_1,
        input  io_busy, io_done, io_err
    );

    modport slave (
        input  io_miss_req, io_miss_addr, io_miss_way, io_flush, io_dec_tlu_core_ecc_disable,
        input  io_bus_valid, io_bus_data, io_bus_err,
        output io_bus_ready, io_ic_wr_en, io_ic_rw_addr, io_ic_wr_data_0, io_ic_wr_data_1,
        output io_busy, io_done, io_err
    );
endinterface

// File: rtl/el2_ifu_ic_refill.sv
// rtl/el2_ifu_ic_refill.sv - I-cache line refill sequencer: 8 bus beats -> 4 two-bank parity-protected array writes
//
// Ports:
//   clock     core clock, rising edge
//   io_rst_l  asynchronous active-low reset
//   ifc       el2_ifu_ic_refill_if.slave (miss request, beat stream, array write port, status)
// A 64-byte line arrives as eight 64-bit beats; each even/odd beat pair becomes one write
// (even beat to bank 0, odd beat to bank 1) presented the cycle after the odd beat.
// Errors and flushes suppress writes but every beat is still consumed.
module el2_ifu_ic_refill (
    input  logic               clock,
    input  logic               io_rst_l,
    el2_ifu_ic_refill_if.slave ifc
);
    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [30:0] base_q;
    logic [1:0]  way_q;
    logic [2:0]  beat_cnt;
    logic        err_q;
    logic [63:0] hold_q;
    logic [3:0]  hold_par_q;
    logic [1:0]  wr_en_q;
    logic [30:0] rw_addr_q;
    logic [70:0] wr_data_0_q;
    logic [70:0] wr_data_1_q;

    logic        accept;
    logic        last_beat;
    logic        fill_write;
    logic        err_now;
    logic [3:0]  beat_par;

    assign accept     = ifc.io_bus_valid & ifc.io_bus_ready;
    assign last_beat  = accept & (beat_cnt == 3'd7);
    // An odd beat in FILL registers a write unless a flush arrives with it.
    assign fill_write = accept & beat_cnt[0] & (state == FILL) & ~ifc.io_flush;
    // Error status including the beat being accepted right now.
    assign err_now    = err_q | ifc.io_bus_err;

    always_comb begin
        beat_par = '0;
        for (int i = 0; i < 4; i++) begin
            beat_par[i] = ~ifc.io_dec_tlu_core_ecc_disable & (^ifc.io_bus_data[16*i +: 16]);
        end
    end

    always_ff @(posedge clock or negedge io_rst_l) begin
        if (!io_rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ifc.io_miss_req) state_nxt = FILL;
            end
            FILL: begin
                // A flush coincident with the last beat has nothing left to drain.
                if (ifc.io_flush)   state_nxt = last_beat ? IDLE : DRAIN;
                else if (last_beat) state_nxt = DONE;
            end
            DRAIN: begin
                if (last_beat) state_nxt = IDLE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ifc.io_bus_ready = (state == FILL) | (state == DRAIN);
        ifc.io_busy      = (state != IDLE);
        ifc.io_done      = (state == DONE);
        ifc.io_err       = (state == DONE) & err_q;
    end

    always_ff @(posedge clock or negedge io_rst_l) begin
        if (!io_rst_l) begin
            base_q      <= '0;
            way_q       <= '0;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
            hold_q      <= '0;
            hold_par_q  <= '0;
            wr_en_q     <= '0;
            rw_addr_q   <= '0;
            wr_data_0_q <= '0;
            wr_data_1_q <= '0;
        end else begin
            wr_en_q <= '0;
            if ((state == IDLE) && ifc.io_miss_req) begin
                base_q   <= ifc.io_miss_addr & ~31'h1F;
                way_q    <= ifc.io_miss_way;
                beat_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + 3'd1;
                err_q    <= err_now;
                if (!beat_cnt[0]) begin
                    hold_q     <= ifc.io_bus_data;
                    hold_par_q <= beat_par;
                end
            end
            if (fill_write) begin
                rw_addr_q   <= base_q + {26'b0, beat_cnt[2:1], 3'b000};
                wr_data_0_q <= {3'b000, hold_par_q, hold_q};
                wr_data_1_q <= {3'b000, beat_par, ifc.io_bus_data};
                wr_en_q     <= err_now ? 2'b00 : way_q;
            end
        end
    end

    assign ifc.io_ic_wr_en     = wr_en_q;
    assign ifc.io_ic_rw_addr   = rw_addr_q;
    assign ifc.io_ic_wr_data_0 = wr_data_0_q;
    assign ifc.io_ic_wr_data_1 = wr_data_1_q;
endmodule

// File: tb/tb_el2_ifu_ic_refill.sv
// tb/tb_el2_ifu_ic_refill.sv - Self-checking bench for el2_ifu_ic_refill
module tb_el2_ifu_ic_refill;
    logic clock = 1'b0;
    logic io_rst_l;
    always #5 clock = ~clock;

    el2_ifu_ic_refill_if ifc();

    el2_ifu_ic_refill dut (
        .clock   (clock),
        .io_rst_l(io_rst_l),
        .ifc     (ifc)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  en;
        logic [30:0] addr;
        logic [70:0] d0;
        logic [70:0] d1;
        int          stamp;
    } wr_t;

    wr_t  wq[$];
    int   done_stamp[$];
    logic done_err[$];
    bit   mon_on = 1'b0;
    wr_t  mon_w;

    always @(negedge clock) begin
        if (mon_on) begin
            if (ifc.io_ic_wr_en != 2'b00) begin
                mon_w.en    = ifc.io_ic_wr_en;
                mon_w.addr  = ifc.io_ic_rw_addr;
                mon_w.d0    = ifc.io_ic_wr_data_0;
                mon_w.d1    = ifc.io_ic_wr_data_1;
                mon_w.stamp = cyc;
                wq.push_back(mon_w);
            end
            if (ifc.io_done) begin
                done_stamp.push_back(cyc);
                done_err.push_back(ifc.io_err);
            end
        end
    end

    logic [63:0] bd[8];
    int err_beat   = -1;
    int flush_beat = -1;
    int bub_after  = 99;
    int bub_len    = 0;
    bit rnd_bub    = 1'b0;
    bit ecc_dis    = 1'b0;
    bit stray_req  = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [70:0] exp_word(input logic [63:0] d, input bit dis);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = dis ? 1'b0 : ^d[16*i +: 16];
        return {3'b000, p, d};
    endfunction

    task automatic refill(input string name, input logic [30:0] addr, input logic [1:0] way);
        int          acc[8];
        int          n;
        int          nexp;
        logic [30:0] base;
        bit          ok;
        wq.delete();
        done_stamp.delete();
        done_err.delete();
        mon_on = 1'b1;
        @(posedge clock); #1;
        ifc.io_miss_req  = 1'b1;
        ifc.io_miss_addr = addr;
        ifc.io_miss_way  = way;
        ifc.io_dec_tlu_core_ecc_disable = ecc_dis;
        @(posedge clock); #1;
        ifc.io_miss_req  = 1'b0;
        ifc.io_miss_addr = 31'($urandom);
        chk({name, " ready_after_req"}, ifc.io_bus_ready, 1);
        chk({name, " busy"}, ifc.io_busy, 1);
        for (int b = 0; b < 8; b++) begin
            n = (b == bub_after + 1) ? bub_len : (rnd_bub ? int'($urandom_range(0, 2)) : 0);
            repeat (n) begin
                if (stray_req) begin
                    ifc.io_miss_req  = 1'b1;
                    ifc.io_miss_addr = 31'($urandom);
                    ifc.io_miss_way  = ~way;
                end
                @(posedge clock); #1;
                ifc.io_miss_req = 1'b0;
            end
            chk($sformatf("%s ready_beat%0d", name, b), ifc.io_bus_ready, 1);
            ifc.io_bus_valid = 1'b1;
            ifc.io_bus_data  = bd[b];
            ifc.io_bus_err   = (b == err_beat);
            ifc.io_flush     = (b == flush_beat);
            @(posedge clock); #1;
            acc[b] = cyc;
            ifc.io_bus_valid = 1'b0;
            ifc.io_bus_err   = 1'b0;
            ifc.io_flush     = 1'b0;
            ifc.io_bus_data  = {$urandom, $urandom};
        end
        repeat (3) @(posedge clock);
        #1;
        mon_on = 1'b0;

        // Reference: pair p is written iff no error and no flush on any beat up to its odd beat.
        base = addr & ~31'h1F;
        nexp = 0;
        for (int p = 0; p < 4; p++) begin
            ok = !(err_beat >= 0 && err_beat <= 2*p + 1) && !(flush_beat >= 0 && flush_beat <= 2*p + 1);
            if (ok) begin
                chk($sformatf("%s write%0d_present", name, p), wq.size() > nexp, 1);
                if (wq.size() > nexp) begin
                    chk($sformatf("%s write%0d_en", name, p), wq[nexp].en, way);
                    chk($sformatf("%s write%0d_addr", name, p), wq[nexp].addr, base + 31'(8 * p));
                    chk($sformatf("%s write%0d_d0", name, p), wq[nexp].d0, exp_word(bd[2*p], ecc_dis));
                    chk($sformatf("%s write%0d_d1", name, p), wq[nexp].d1, exp_word(bd[2*p+1], ecc_dis));
                    chk($sformatf("%s write%0d_time", name, p), wq[nexp].stamp, acc[2*p+1]);
                end
                nexp++;
            end
        end
        chk({name, " write_count"}, wq.size(), nexp);
        if (flush_beat < 0) begin
            chk({name, " done_count"}, done_stamp.size(), 1);
            if (done_stamp.size() > 0) begin
                chk({name, " done_time"}, done_stamp[0], acc[7]);
                chk({name, " done_err"}, done_err[0], (err_beat >= 0));
            end
        end else begin
            chk({name, " no_done"}, done_stamp.size(), 0);
        end
        chk({name, " idle_busy"}, ifc.io_busy, 0);
        chk({name, " idle_ready"}, ifc.io_bus_ready, 0);
    endtask

    task automatic set_defaults();
        err_beat   = -1;
        flush_beat = -1;
        bub_after  = 99;
        bub_len    = 0;
        rnd_bub    = 1'b0;
        ecc_dis    = 1'b0;
        stray_req  = 1'b0;
        for (int i = 0; i < 8; i++) bd[i] = {$urandom, $urandom};
    endtask

    initial begin
        io_rst_l = 1'b0;
        ifc.io_miss_req = 1'b0;
        ifc.io_miss_addr = '0;
        ifc.io_miss_way = '0;
        ifc.io_flush = 1'b0;
        ifc.io_dec_tlu_core_ecc_disable = 1'b0;
        ifc.io_bus_valid = 1'b0;
        ifc.io_bus_data = '0;
        ifc.io_bus_err = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst wr_en", ifc.io_ic_wr_en, 0);
        chk("rst addr", ifc.io_ic_rw_addr, 0);
        chk("rst d0", ifc.io_ic_wr_data_0, 0);
        chk("rst d1", ifc.io_ic_wr_data_1, 0);
        chk("rst busy", ifc.io_busy, 0);
        chk("rst done", ifc.io_done, 0);
        chk("rst err", ifc.io_err, 0);
        chk("rst ready", ifc.io_bus_ready, 0);
        @(negedge clock);
        io_rst_l = 1'b1;

        set_defaults();
        for (int i = 0; i < 8; i++) bd[i] = 64'(i);
        refill("basic", 31'h1234, 2'b01);

        set_defaults();
        bd[0] = 64'h1;
        refill("par_on", 31'h0400, 2'b10);
        chk("par_on have", wq.size() > 0, 1);
        if (wq.size() > 0) chk("par_on d0", wq[0].d0, 71'h1_0000_0000_0000_0001);

        set_defaults();
        bd[0] = 64'h1;
        ecc_dis = 1'b1;
        refill("par_off", 31'h0400, 2'b01);
        chk("par_off have", wq.size() > 0, 1);
        if (wq.size() > 0) chk("par_off d0", wq[0].d0, 71'h0_0000_0000_0000_0001);

        set_defaults();
        bub_after = 2;
        bub_len   = 3;
        stray_req = 1'b1;
        refill("bubble", 31'h0777_0003, 2'b10);

        set_defaults();
        err_beat = 5;
        refill("err5", 31'h2000, 2'b01);

        set_defaults();
        err_beat = 0;
        refill("err0", 31'h2040, 2'b10);

        set_defaults();
        flush_beat = 3;
        refill("flush3", 31'h3000, 2'b01);

        set_defaults();
        flush_beat = 7;
        refill("flush7", 31'h3100, 2'b10);

        for (int r = 0; r < 8; r++) begin
            set_defaults();
            rnd_bub    = 1'b1;
            ecc_dis    = $urandom_range(0, 1) == 1;
            err_beat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            flush_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            refill($sformatf("rand%0d", r), 31'($urandom), $urandom_range(0, 1) == 1 ? 2'b01 : 2'b10);
        end

        // Reset in the middle of a fill, after a write has left the address register non-zero.
        set_defaults();
        @(posedge clock); #1;
        ifc.io_miss_req  = 1'b1;
        ifc.io_miss_addr = 31'h5A40;
        ifc.io_miss_way  = 2'b01;
        @(posedge clock); #1;
        ifc.io_miss_req = 1'b0;
        for (int b = 0; b < 5; b++) begin
            ifc.io_bus_valid = 1'b1;
            ifc.io_bus_data  = bd[b];
            ifc.io_bus_err   = (b == 4);
            @(posedge clock); #1;
        end
        ifc.io_bus_valid = 1'b0;
        ifc.io_bus_err   = 1'b0;
        chk("pre_rst busy", ifc.io_busy, 1);
        chk("pre_rst addr", ifc.io_ic_rw_addr, 31'h5A48);
        #1;
        io_rst_l = 1'b0;
        #1;
        chk("async_rst addr", ifc.io_ic_rw_addr, 0);
        chk("async_rst d0", ifc.io_ic_wr_data_0, 0);
        chk("async_rst d1", ifc.io_ic_wr_data_1, 0);
        chk("async_rst busy", ifc.io_busy, 0);
        chk("async_rst ready", ifc.io_bus_ready, 0);
        chk("async_rst wr_en", ifc.io_ic_wr_en, 0);
        @(negedge clock);
        io_rst_l = 1'b1;
        set_defaults();
        refill("after_rst", 31'h6000, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
